spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 175 +++++++++++++++++
 tb/tb_spi_slave.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave, all four CPOL/CPHA modes, oversampled on clk.
// spi_clk, cs and mosi are synchronized and sampled; spi_clk half-periods must be >= 4 clk.
module spi_slave #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  polarity,
  input  logic                  phase,
  input  logic                  spi_clk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] data_wr,
  output logic [DATA_WIDTH-1:0] data_rd,
  output logic                  rx_valid,
  output logic                  busy,
  output logic [3:0]            state,
  output logic [3:0]            count
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] LOAD  = 4'd1;
  localparam logic [3:0] SHIFT = 4'd2;
  localparam logic [3:0] DONE  = 4'd3;

  localparam logic [3:0]            LAST_BIT = 4'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MSB_ONE  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  logic [3:0]            state_q, state_d;
  logic [3:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-2:0] rx_q, rx_d;
  logic                  pol_q, pol_d;
  logic                  pha_q, pha_d;
  logic                  miso_q, miso_d;
  logic [DATA_WIDTH-1:0] data_rd_q, data_rd_d;
  logic                  rx_valid_q, rx_valid_d;

  logic                  sclk_edge, lead_edge, trail_edge;
  logic                  sample_edge, drive_edge;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [3:0]            count_inc;
  logic                  tx_bit;

  // cs_prev_q resets low so a cs already low at reset release is not a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      cs_meta_q   <= 1'b0;
      cs_sync_q   <= 1'b0;
      cs_prev_q   <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      sclk_meta_q <= spi_clk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      cs_meta_q   <= cs;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      mosi_meta_q <= mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign sclk_edge   = sclk_sync_q ^ sclk_prev_q;
  assign lead_edge   = sclk_edge & (sclk_sync_q ^ pol_q);
  assign trail_edge  = sclk_edge & ~(sclk_sync_q ^ pol_q);
  assign sample_edge = pha_q ? trail_edge : lead_edge;
  assign drive_edge  = pha_q ? lead_edge : trail_edge;
  assign rx_next     = {rx_q, mosi_sync_q};
  assign count_inc   = count_q + 4'd1;
  // Next transmit bit is indexed by bits already sampled; in CPHA=1 the first drive re-sends the MSB.
  assign tx_bit      = |(tx_q & (MSB_ONE >> count_q));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    pol_d      = pol_q;
    pha_d      = pha_q;
    miso_d     = miso_q;
    data_rd_d  = data_rd_q;
    rx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (!cs_sync_q && cs_prev_q) state_d = LOAD;
      end
      LOAD: begin
        count_d = 4'd0;
        if (cs_sync_q) begin
          miso_d  = 1'b0;
          state_d = IDLE;
        end else begin
          tx_d    = data_wr;
          rx_d    = '0;
          pol_d   = polarity;
          pha_d   = phase;
          miso_d  = data_wr[DATA_WIDTH-1];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // cs release outranks any spi_clk edge seen in the same clk.
        if (cs_sync_q) begin
          count_d = 4'd0;
          miso_d  = 1'b0;
          state_d = IDLE;
        end else if (sample_edge) begin
          rx_d    = rx_next[DATA_WIDTH-2:0];
          count_d = count_inc;
          if (count_inc == LAST_BIT) begin
            data_rd_d  = rx_next;
            rx_valid_d = 1'b1;
            state_d    = DONE;
          end
        end else if (drive_edge) begin
          miso_d = tx_bit;
        end
      end
      DONE: begin
        if (cs_sync_q) begin
          miso_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        count_d = 4'd0;
        miso_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= 4'd0;
      tx_q       <= '0;
      rx_q       <= '0;
      pol_q      <= 1'b0;
      pha_q      <= 1'b0;
      miso_q     <= 1'b0;
      data_rd_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      pol_q      <= pol_d;
      pha_q      <= pha_d;
      miso_q     <= miso_d;
      data_rd_q  <= data_rd_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign miso     = miso_q;
  assign data_rd  = data_rd_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != IDLE);
  assign state    = state_q;
  assign count    = count_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - testbench for spi_slave: mode table, abort, reset and back-to-back sequences.
`timescale 1ns/1ps
module tb_spi_slave;

  localparam int H = 6;

  logic       clk = 1'b0;
  logic       reset, polarity, phase, spi_clk, cs, mosi;
  logic       miso;
  logic [7:0] data_wr, data_rd;
  logic       rx_valid, busy;
  logic [3:0] state, count;

  always #5 clk = ~clk;

  spi_slave #(.DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .polarity(polarity), .phase(phase),
    .spi_clk(spi_clk), .cs(cs), .mosi(mosi), .miso(miso),
    .data_wr(data_wr), .data_rd(data_rd), .rx_valid(rx_valid),
    .busy(busy), .state(state), .count(count)
  );

  typedef struct {
    bit         pol;
    bit         pha;
    logic [7:0] wr;
    logic [7:0] tx;
    logic [7:0] exp_miso;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t       vecs[6];
  int         n_pass = 0;
  int         n_total = 0;
  int         n_pulses = 0;
  logic [7:0] exp_q[$];
  bit         m_pol, m_pha;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // Scoreboard: every rx_valid pulse must match the next queued byte.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL rx_valid_spurious: got pulse with data_rd=%0h expected none", data_rd);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("rx_data", 32'(data_rd), 32'(e));
      end
    end
  end

  task automatic set_mode(input bit pol, input bit pha);
    m_pol   = pol;
    m_pha   = pha;
    spi_clk = pol;
    tick(4);
  endtask

  // Master side of one frame; inputs are scrambled after LOAD to prove they are captured.
  task automatic xfer(input logic [7:0] wr, input logic [7:0] tx, input int nbits,
                      output logic [7:0] rx);
    polarity = m_pol;
    phase    = m_pha;
    data_wr  = wr;
    cs       = 1'b0;
    tick(8);
    data_wr  = ~wr;
    polarity = ~m_pol;
    phase    = ~m_pha;
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!m_pha) begin
        mosi = tx[7-i];
        tick(H);
        spi_clk = ~m_pol;
        rx = {rx[6:0], miso};
        tick(H);
        spi_clk = m_pol;
      end else begin
        spi_clk = ~m_pol;
        mosi = tx[7-i];
        tick(H);
        spi_clk = m_pol;
        rx = {rx[6:0], miso};
        tick(H);
      end
    end
    tick(H);
  endtask

  task automatic end_frame(input int gap);
    cs = 1'b1;
    tick(gap);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rx;
    int         p0;

    vecs[0] = '{1'b0, 1'b0, 8'hAB, 8'h5C, 8'hAB, 8'h5C};
    vecs[1] = '{1'b0, 1'b1, 8'hAB, 8'hA5, 8'hAB, 8'hA5};
    vecs[2] = '{1'b1, 1'b0, 8'h3C, 8'hC3, 8'h3C, 8'hC3};
    vecs[3] = '{1'b1, 1'b1, 8'h3C, 8'hC3, 8'h3C, 8'hC3};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[5] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00};

    reset = 1'b1; cs = 1'b0; spi_clk = 1'b0; mosi = 1'b0;
    polarity = 1'b0; phase = 1'b0; data_wr = 8'hA5;
    tick(3);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_data_rd", 32'(data_rd), 32'h00);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_miso", 32'(miso), 32'd0);

    reset = 1'b0;
    tick(10);
    chk("no_start_cs_low_at_release", 32'(state), 32'd0);
    cs = 1'b1;
    tick(4);

    for (int v = 0; v < 6; v++) begin
      set_mode(vecs[v].pol, vecs[v].pha);
      exp_q.push_back(vecs[v].exp_rd);
      xfer(vecs[v].wr, vecs[v].tx, 8, rx);
      chk($sformatf("v%0d_master_read", v), 32'(rx), 32'(vecs[v].exp_miso));
      chk($sformatf("v%0d_data_rd", v), 32'(data_rd), 32'(vecs[v].exp_rd));
      chk($sformatf("v%0d_state_done", v), 32'(state), 32'd3);
      chk($sformatf("v%0d_count", v), 32'(count), 32'd8);
      chk($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
      end_frame(6);
      chk($sformatf("v%0d_state_idle", v), 32'(state), 32'd0);
      chk($sformatf("v%0d_idle_busy", v), 32'(busy), 32'd0);
      chk($sformatf("v%0d_idle_miso", v), 32'(miso), 32'd0);
    end

    // Abort after 5 bits keeps the previous byte.
    set_mode(1'b0, 1'b0);
    exp_q.push_back(8'h5C);
    xfer(8'h96, 8'h5C, 8, rx);
    chk("pre_abort_master_read", 32'(rx), 32'h96);
    end_frame(6);
    p0 = n_pulses;
    xfer(8'hAB, 8'hFF, 5, rx);
    chk("abort_mid_count", 32'(count), 32'd5);
    chk("abort_mid_state", 32'(state), 32'd2);
    end_frame(6);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_data_rd", 32'(data_rd), 32'h5C);
    chk("abort_no_pulse", 32'(n_pulses - p0), 32'd0);
    exp_q.push_back(8'h12);
    xfer(8'hAB, 8'h12, 8, rx);
    chk("after_abort_data_rd", 32'(data_rd), 32'h12);
    end_frame(6);

    // Back-to-back frames, then extra spi_clk edges while DONE.
    set_mode(1'b1, 1'b1);
    p0 = n_pulses;
    exp_q.push_back(8'h01);
    xfer(8'h55, 8'h01, 8, rx);
    chk("b2b_first_master_read", 32'(rx), 32'h55);
    end_frame(4);
    exp_q.push_back(8'h80);
    xfer(8'hC3, 8'h80, 8, rx);
    chk("b2b_second_master_read", 32'(rx), 32'hC3);
    chk("b2b_second_data_rd", 32'(data_rd), 32'h80);
    for (int k = 0; k < 2; k++) begin
      spi_clk = ~m_pol;
      tick(H);
      spi_clk = m_pol;
      tick(H);
    end
    chk("done_ignores_edges_state", 32'(state), 32'd3);
    chk("done_ignores_edges_count", 32'(count), 32'd8);
    end_frame(6);
    chk("b2b_pulses", 32'(n_pulses - p0), 32'd2);

    // Asynchronous reset after 3 bits.
    set_mode(1'b0, 1'b0);
    xfer(8'h3C, 8'hF0, 3, rx);
    chk("pre_reset_count", 32'(count), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("midreset_state", 32'(state), 32'd0);
    chk("midreset_count", 32'(count), 32'd0);
    chk("midreset_data_rd", 32'(data_rd), 32'h00);
    chk("midreset_rx_valid", 32'(rx_valid), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_miso", 32'(miso), 32'd0);
    tick(3);
    reset = 1'b0;
    tick(10);
    chk("post_reset_no_start", 32'(state), 32'd0);
    cs = 1'b1;
    tick(4);
    exp_q.push_back(8'h81);
    xfer(8'h7E, 8'h81, 8, rx);
    chk("post_reset_master_read", 32'(rx), 32'h7E);
    chk("post_reset_data_rd", 32'(data_rd), 32'h81);
    end_frame(6);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
